serial_addsub: RTL

Parametrised digit-serial adder/subtractor. Operands of `WIDTH` bits are captured in parallel, processed `DIGIT` bits per clock through a single `DIGIT`-bit ripple adder slice plus a carry flop, and returned as a parallel result. It is used wherever area matters more than latency in the datapath. It replaces the fixed 8-bit, 1-bit-per-cycle, add-only serial adder. It adds subtraction, a configurable digit width, and valid/ready handshakes on both sides.

---
 rtl/serial_addsub.sv | 135 +++++++++++++
 1 files changed

// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor: WIDTH-bit operands, DIGIT bits per clock through one ripple slice.
// Define SERIAL_ADDSUB_OVF_EN to add the signed-overflow output ovf_out.
module serial_addsub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sub,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out
`ifdef SERIAL_ADDSUB_OVF_EN
  ,output logic            ovf_out
`endif
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic [DIGIT:0]         slice;
  logic [WIDTH+DIGIT-1:0] res_cat;
  logic                   last;

  assign slice   = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
  // New digit enters from the MSB side; the low DIGIT bits of the old result drop off.
  assign res_cat = {slice[DIGIT-1:0], res_q};
  assign last    = (cnt_q == CW'(N - 1));

`ifdef SERIAL_ADDSUB_OVF_EN
  logic ovf_q, ovf_d;
  logic msb_cin;
  // Carry into the MSB recovered from the top bit of the final slice.
  assign msb_cin = slice[DIGIT-1] ^ a_q[DIGIT-1] ^ b_q[DIGIT-1];
  assign ovf_out = ovf_q;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADDSUB_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a_in;
          b_d     = sub ? ~b_in : b_in;
          carry_d = sub;
          cnt_d   = '0;
          res_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        res_d   = res_cat[WIDTH+DIGIT-1:DIGIT];
        carry_d = slice[DIGIT];
        if (last) begin
          sum_d   = res_cat[WIDTH+DIGIT-1:DIGIT];
          cout_d  = slice[DIGIT];
`ifdef SERIAL_ADDSUB_OVF_EN
          ovf_d   = msb_cin ^ slice[DIGIT];
`endif
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADDSUB_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign sum_out   = sum_q;
  assign carry_out = cout_q;

endmodule
